gray_counter: RTL

Parametrised, registered Gray-code up/down counter. It provides binary and Gray views of the same count. It supports a parallel load in either binary or Gray encoding and flags wrap-around. It is the sequential successor to the team's combinational binary-to-Gray converter and targets async-FIFO pointers and glitch-free position/state encoding.

---
 rtl/gray_counter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Registered up/down counter that keeps a binary and a Gray view of the same
// count. Typical uses are async-FIFO pointers and glitch-free position or
// state encoding. Supports a parallel load in either binary or Gray encoding
// and a registered terminal-count flag.
//
// Priority at each rising clock edge is rst > load > en.
//
// Optional build macro:
//   GRAY_COUNTER_SAT_EN - when defined, the counter saturates at the ends of
//                         its range instead of wrapping. tc is raised on every
//                         cycle that requests an out-of-range step.
//
// Parameters:
//   WIDTH     - counter width in bits (1..32)
//   RESET_VAL - binary count loaded on reset (must be < 2**WIDTH)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   en        in   count enable, one step per cycle while high
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   parallel load strobe (overrides en/up)
//   load_gray in   encoding of load_val: 1 = Gray, 0 = binary
//   load_val  in   [WIDTH] load value
//   bin_out   out  [WIDTH] registered binary count
//   gray_out  out  [WIDTH] registered Gray count, bin_out ^ (bin_out >> 1)
//   tc        out  registered terminal-count flag
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module gray_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
    // above its position, built MSB-first.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q,   tc_d;

    // Edge conditions of the current count relative to the requested step.
    logic at_max;
    logic at_min;

    assign at_max = (bin_q == MAX_VAL);
    assign at_min = (bin_q == MIN_VAL);

    // Next-state logic. tc defaults low so that hold, load and normal steps
    // all clear it; only an edge step raises it.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;

        if (load) begin
            bin_d = load_gray ? gray2bin(load_val) : load_val;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef GRAY_COUNTER_SAT_EN
                    bin_d = bin_q;
`else
                    bin_d = MIN_VAL;
`endif
                    tc_d  = 1'b1;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (at_min) begin
`ifdef GRAY_COUNTER_SAT_EN
                    bin_d = bin_q;
`else
                    bin_d = MAX_VAL;
`endif
                    tc_d  = 1'b1;
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end

        // Gray view is always derived from the next binary value, so the two
        // registers can never disagree.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= RESET_BIN;
            gray_q <= RESET_GRAY;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;

endmodule
